// File: rtl/fetch_prefetch_stage_pkg.sv
// Shared fetch-stage constants: widths, reset vector and queue sizing.
package fetch_prefetch_stage_pkg;

    localparam int unsigned PKG_XLEN            = 64;
    localparam int unsigned PKG_ILEN            = 32;
    localparam int unsigned PKG_DEPTH           = 4;
    localparam int unsigned PKG_MAX_OUTSTANDING = 2;

    localparam logic [63:0] PKG_RESET_ADDR = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/fetch_prefetch_stage_sync_fifo.sv
// Synchronous FIFO with clear and a bulk-set of each entry's top bit.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             mark_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_wdata;

    assign w_pop   = pop_i & (r_cnt != '0);
    assign w_push  = push_i & ((r_cnt != CW'(DEPTH)) | w_pop);
    assign w_wdata = {wdata_i[WIDTH-1] | mark_i, wdata_i[WIDTH-2:0]};
    assign rdata_o = (r_cnt == '0) ? '0 : r_mem[r_rptr];
    assign count_o = r_cnt;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A push in a marking cycle carries the mark too, so it lands after the loop.
    always_ff @(posedge clk_i) begin
        if (mark_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i][WIDTH-1] <= 1'b1;
            end
        end
        if (w_push && !clr_i) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= inc(r_wptr);
            if (w_pop)  r_rptr <= inc(r_rptr);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Decoupled fetch: pipelined OBI reads into a prefetch queue with flush.
module fetch_prefetch_stage
    import fetch_prefetch_stage_pkg::*;
#(
    parameter int unsigned      XLEN            = PKG_XLEN,
    parameter logic [XLEN-1:0]  RESET_ADDR      = PKG_RESET_ADDR,
    parameter int unsigned      DEPTH           = PKG_DEPTH,
    parameter int unsigned      MAX_OUTSTANDING = PKG_MAX_OUTSTANDING
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [XLEN-1:0]     flush_addr_i,
    output logic                imem_req_o,
    output logic [XLEN-1:0]     imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [PKG_ILEN-1:0] imem_rdata_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [PKG_ILEN-1:0] instr_o,
    output logic [XLEN-1:0]     pc_o,
    output logic [XLEN-1:0]     next_pc_o
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned TCW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned PW  = XLEN + PKG_ILEN;

    logic [XLEN-1:0] r_fpc;
    logic            r_req;
    logic            r_req_stale;
    logic [XLEN-1:0] r_addr;
    logic [CW-1:0]   r_out;

    logic [XLEN:0]   w_tag_rdata;
    logic [TCW-1:0]  w_tag_cnt;
    logic [PW-1:0]   w_pf_rdata;
    logic [CW-1:0]   w_pf_cnt;
    logic            w_gnt;
    logic            w_rsp;
    logic            w_push;
    logic            w_pop;
    logic            w_pend;
    logic            w_issue;
    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW:0]     w_sum_nxt;
    logic [XLEN-1:0] w_fpc_src;

    assign w_gnt     = r_req & imem_gnt_i;
    assign w_rsp     = imem_rvalid_i & (w_tag_cnt != '0);
    assign w_push    = w_rsp & ~w_tag_rdata[XLEN] & ~flush_i;
    assign w_pop     = valid_o & ready_i & ~flush_i;
    assign w_out_nxt = r_out + CW'(w_gnt) - CW'(w_rsp);
    assign w_cnt_nxt = flush_i ? '0 : w_pf_cnt + CW'(w_push) - CW'(w_pop);
    assign w_sum_nxt = {1'b0, w_cnt_nxt} + {1'b0, w_out_nxt};
    assign w_pend    = r_req & ~imem_gnt_i;
    // Every read reserves a queue slot, so a response always has room.
    assign w_issue   = ~w_pend
                     & (w_out_nxt < CW'(MAX_OUTSTANDING))
                     & (w_sum_nxt < (CW + 1)'(DEPTH));
    assign w_fpc_src = flush_i ? {flush_addr_i[XLEN-1:2], 2'b00} : r_fpc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fpc       <= RESET_ADDR;
            r_req       <= 1'b0;
            r_req_stale <= 1'b0;
            r_addr      <= '0;
            r_out       <= '0;
        end else begin
            r_out <= w_out_nxt;
            r_fpc <= w_issue ? w_fpc_src + XLEN'(4) : w_fpc_src;
            if (w_pend) begin
                if (flush_i) r_req_stale <= 1'b1;
            end else begin
                r_req       <= w_issue;
                r_req_stale <= 1'b0;
                if (w_issue) r_addr <= w_fpc_src;
            end
        end
    end

    sync_fifo #(
        .WIDTH (XLEN + 1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (1'b0),
        .mark_i  (flush_i),
        .push_i  (w_gnt),
        .wdata_i ({r_req_stale, r_addr}),
        .pop_i   (w_rsp),
        .rdata_o (w_tag_rdata),
        .count_o (w_tag_cnt)
    );

    sync_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_pf_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (flush_i),
        .mark_i  (1'b0),
        .push_i  (w_push),
        .wdata_i ({w_tag_rdata[XLEN-1:0], imem_rdata_i}),
        .pop_i   (w_pop),
        .rdata_o (w_pf_rdata),
        .count_o (w_pf_cnt)
    );

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_addr;
    assign valid_o     = (w_pf_cnt != '0);
    assign instr_o     = w_pf_rdata[PKG_ILEN-1:0];
    assign pc_o        = w_pf_rdata[PW-1:PKG_ILEN];
    assign next_pc_o   = valid_o ? pc_o + XLEN'(4) : '0;

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Scoreboard bench for fetch_prefetch_stage with a pipelined OBI memory model.
module tb_fetch_prefetch_stage;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    typedef struct {
        int          due;
        logic [63:0] a;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [63:0] flush_addr_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic [63:0] next_pc_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tick_no;
    int          lat;
    int          n_gnt;
    int          n_acc;
    int          fv;
    bit          gnt_en;
    bit          prev_pend;
    logic [63:0] prev_addr;
    logic [63:0] watch_base;
    logic [63:0] exp_q [$];
    rsp_t        rsp_q [$];

    always #5 clk = ~clk;

    fetch_prefetch_stage #(
        .XLEN            (64),
        .RESET_ADDR      (RST_PC),
        .DEPTH           (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .flush_addr_i  (flush_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .next_pc_o     (next_pc_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
    endfunction

    task automatic fill(input logic [63:0] base);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(base + 64'(4 * i));
    endtask

    task automatic do_flush(input logic [63:0] a);
        flush_i      = 1'b1;
        flush_addr_i = a;
        fill({a[63:2], 2'b00});
    endtask

    // Called at a falling edge with this cycle's control inputs set.
    task automatic tick();
        rsp_t        r;
        logic [63:0] e;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == tick_no) begin
            r             = rsp_q.pop_front();
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_f(r.a);
        end
        imem_gnt_i = gnt_en;
        #1;
        if (prev_pend) begin
            chk("obi_req_hold", 64'(imem_req_o), 64'd1);
            chk("obi_addr_hold", imem_addr_o, prev_addr);
        end
        if (valid_o && fv < 0) fv = tick_no;
        if (valid_o && ready_i && !flush_i) begin
            n_acc++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            chk("pc", pc_o, e);
            chk("instr", 64'(instr_o), 64'(mem_f(e)));
            chk("next_pc", next_pc_o, e + 64'd4);
        end
        prev_pend = imem_req_o && !imem_gnt_i;
        prev_addr = imem_addr_o;
        if (imem_req_o && imem_gnt_i) begin
            n_gnt++;
            if (watch_base != '0)
                chk("b2b_gnt", imem_addr_o & ~64'hFFF, watch_base);
            r.due = tick_no + lat;
            r.a   = imem_addr_o;
            rsp_q.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
        tick_no++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        flush_addr_i  = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        rsp_q.delete();
        prev_pend     = 1'b0;
        watch_base    = '0;
        #1;
        chk("rst_req", 64'(imem_req_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_pc", pc_o, 64'd0);
        chk("rst_npc", next_pc_o, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni  = 1'b1;
        tick_no = 0;
        n_gnt   = 0;
        n_acc   = 0;
        fv      = -1;
        fill(RST_PC);
    endtask

    initial begin
        ready_i = 1'b1;
        gnt_en  = 1'b1;
        lat     = 1;
        rst_ni  = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_instr", 64'(instr_o), 64'd0);
        chk("rst_addr", imem_addr_o, 64'd0);

        // Streaming: one instruction per cycle, first valid in cycle 3.
        ticks(20);
        chk("lat_first_valid", 64'(fv), 64'd3);
        chk("stream_nacc", 64'(n_acc), 64'd17);

        // Asynchronous reset in the middle of a burst.
        rst_ni = 1'b0;
        #1;
        chk("midrst_req", 64'(imem_req_o), 64'd0);
        chk("midrst_valid", 64'(valid_o), 64'd0);
        do_reset();
        tick();
        chk("post_rst_req", 64'(imem_req_o), 64'd1);
        chk("post_rst_addr", imem_addr_o, RST_PC);
        ticks(6);

        // Backpressure: exactly DEPTH grants, then one issue per pop.
        do_reset();
        ready_i = 1'b0;
        ticks(12);
        chk("bp_grants", 64'(n_gnt), 64'd4);
        chk("bp_req_low", 64'(imem_req_o), 64'd0);
        chk("bp_valid", 64'(valid_o), 64'd1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        ticks(6);
        chk("bp_one_more", 64'(n_gnt), 64'd5);
        chk("bp_nacc", 64'(n_acc), 64'd1);
        ready_i = 1'b1;
        ticks(8);

        // Flush with two reads outstanding.
        do_reset();
        lat = 2;
        ticks(3);
        do_flush(64'h0000_0000_8000_0100);
        tick();
        flush_i = 1'b0;
        chk("fl2_req", 64'(imem_req_o), 64'd1);
        chk("fl2_addr", imem_addr_o, 64'h0000_0000_8000_0100);
        n_acc = 0;
        ticks(12);
        chk("fl2_nacc", 64'(n_acc != 0), 64'd1);
        lat = 1;
        ticks(4);

        // Flush while a request waits three cycles for its grant.
        do_reset();
        gnt_en = 1'b0;
        ticks(2);
        chk("pend_addr", imem_addr_o, RST_PC);
        do_flush(64'h0000_0000_8000_0203);
        tick();
        flush_i = 1'b0;
        ticks(2);
        gnt_en = 1'b1;
        tick();
        chk("pend_next_req", 64'(imem_req_o), 64'd1);
        chk("pend_next_addr", imem_addr_o, 64'h0000_0000_8000_0200);
        n_acc = 0;
        ticks(10);
        chk("pend_nacc", 64'(n_acc), 64'd8);

        // Flush colliding with a response and a pop, then back-to-back flushes.
        do_reset();
        ticks(8);
        do_flush(64'h0000_0000_8000_0400);
        tick();
        flush_i = 1'b0;
        chk("coll_empty", 64'(valid_o), 64'd0);
        ticks(5);
        do_flush(64'h0000_0000_9000_0000);
        tick();
        do_flush(64'h0000_0000_A000_0000);
        tick();
        flush_i    = 1'b0;
        watch_base = 64'h0000_0000_A000_0000;
        n_acc      = 0;
        ticks(12);
        watch_base = '0;
        chk("b2b_nacc", 64'(n_acc != 0), 64'd1);

        // Random grant/ready/flush traffic.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            gnt_en  = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0)
                do_flush(64'h0000_0000_4000_0000 +
                         64'($urandom_range(0, 255) << 4) +
                         64'($urandom_range(0, 3)));
            tick();
            flush_i = 1'b0;
        end
        gnt_en  = 1'b1;
        ready_i = 1'b1;
        ticks(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
